// File: rtl/multiplier_booth_r4.sv
// Signed Q(WIDTH-FRAC).FRAC multiplier, radix-4 Booth, 2 multiplier bits per cycle.
// Define MULT_BOOTH_SAT_EN to saturate the result on overflow instead of wrapping.
module multiplier_booth_r4 #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_multiplicand,
  input  logic [WIDTH-1:0] i_multiplier,
  input  logic             i_rnd_mode,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_overflow_flag
);

  localparam int AW    = WIDTH + 2;
  localparam int PW    = 2 * WIDTH;
  localparam int HW    = PW - FRAC;
  localparam int STEPS = WIDTH / 2;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH:0]   r_q;
  logic [AW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_rnd;
  logic [WIDTH-1:0] r_result;
  logic             r_ovf;

  logic             w_load, w_step, w_fin;
  logic [AW-1:0]    w_mx, w_m2, w_pp, w_sum, w_acc_nxt;
  logic [WIDTH:0]   w_q_nxt;
  logic [HW-1:0]    w_p_hi, w_r_hi;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_state_nxt = S_CALC;
        w_load      = 1'b1;
      end
      S_CALC: begin
        w_step = 1'b1;
        if (r_cnt == CW'(STEPS - 1)) begin
          w_state_nxt = S_DONE;
          w_fin       = 1'b1;
        end
      end
      S_DONE: begin
        if (i_start) begin
          w_state_nxt = S_CALC;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Booth digit from the overlapping triplet; acc is two bits wider so +-2M never wraps.
  always_comb begin
    w_mx = {{2{r_m[WIDTH-1]}}, r_m};
    w_m2 = {w_mx[AW-2:0], 1'b0};
    case (r_q[2:0])
      3'b001, 3'b010: w_pp = w_mx;
      3'b011:         w_pp = w_m2;
      3'b100:         w_pp = -w_m2;
      3'b101, 3'b110: w_pp = -w_mx;
      default:        w_pp = '0;
    endcase
    w_sum     = r_acc + w_pp;
    w_acc_nxt = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
    w_q_nxt   = {w_sum[1:0], r_q[WIDTH:2]};
  end

  // Product is {acc[W-1:0], q[W:1]} after the last step; rounding only carries into bit FRAC.
  always_comb begin
    w_p_hi = {w_acc_nxt[WIDTH-1:0], w_q_nxt[WIDTH:FRAC+1]};
    w_r_hi = w_p_hi + HW'(r_rnd & w_q_nxt[FRAC]);
    w_ovf  = !((&w_r_hi[HW-1:WIDTH-1]) || !(|w_r_hi[HW-1:WIDTH-1]));
`ifdef MULT_BOOTH_SAT_EN
    if (w_ovf)
      w_res = w_r_hi[HW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      w_res = w_r_hi[WIDTH-1:0];
`else
    w_res = w_r_hi[WIDTH-1:0];
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_m      <= '0;
      r_q      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_rnd    <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_m   <= i_multiplicand;
        r_q   <= {i_multiplier, 1'b0};
        r_rnd <= i_rnd_mode;
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_step) begin
        r_acc <= w_acc_nxt;
        r_q   <= w_q_nxt;
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_fin) begin
        r_result <= w_res;
        r_ovf    <= w_ovf;
      end
    end
  end

  assign o_busy          = (r_state == S_CALC);
  assign o_done          = (r_state == S_DONE);
  assign o_result        = r_result;
  assign o_overflow_flag = r_ovf;

endmodule

// File: tb/tb_multiplier_booth_r4.sv
// Bench for multiplier_booth_r4 (WIDTH=16, FRAC=7): cycle-level reference model plus directed literals.
module tb_multiplier_booth_r4;

  localparam int W = 16;
  localparam int F = 7;

  logic         clk = 1'b0;
  logic         rst, start, rnd;
  logic [W-1:0] m, q;
  logic         o_busy, o_done, o_ovf;
  logic [W-1:0] o_result;

  int checks = 0;
  int errors = 0;

  multiplier_booth_r4 #(.WIDTH(W), .FRAC(F)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_multiplicand(m), .i_multiplier(q), .i_rnd_mode(rnd),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result), .o_overflow_flag(o_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Plain integer arithmetic: full product, optional half-LSB add, floor shift, range test.
  function automatic void ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit r,
                                  output logic [W-1:0] res, output bit ov);
    longint p, h;
    p = longint'($signed(a)) * longint'($signed(b));
    if (r) p += longint'(1) << (F - 1);
    h   = p >>> F;
    ov  = (h > 32767) || (h < -32768);
    res = h[W-1:0];
`ifdef MULT_BOOTH_SAT_EN
    if (ov) res = (p < 0) ? 16'h8000 : 16'h7FFF;
`endif
  endfunction

  // Model: an accepted op keeps busy for W/2 edges, then done with results for one cycle.
  int           left = 0;
  bit           e_done = 0, e_ovf = 0, p_ovf = 0;
  logic [W-1:0] e_res = '0, p_res = '0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        left = 0; e_done = 0; e_res = '0; e_ovf = 0;
      end else if (left > 0) begin
        left--;
        if (left == 0) begin
          e_done = 1; e_res = p_res; e_ovf = p_ovf;
        end
      end else begin
        e_done = 0;
        if (start) begin
          left = W / 2;
          ref_mul(m, q, rnd, p_res, p_ovf);
        end
      end
      #1;
      chk("mdl_busy", 32'(o_busy), 32'(left > 0));
      chk("mdl_done", 32'(o_done), 32'(e_done));
      chk("mdl_result", 32'(o_result), 32'(e_res));
      chk("mdl_ovf", 32'(o_ovf), 32'(e_ovf));
    end
  end

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input bit r,
                    output logic [W-1:0] res, output bit ov, output int lat, output int bc);
    @(negedge clk);
    start = 1; m = a; q = b; rnd = r; lat = 0; bc = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 0; m = W'($urandom); q = W'($urandom); rnd = 1'($urandom);
      end
      if (o_busy) bc++;
    end while (!o_done && lat < 40);
    res = o_result;
    ov  = o_ovf;
  endtask

  task automatic dir(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input bit r,
                     input logic [W-1:0] eres, input bit eovf);
    logic [W-1:0] res;
    bit           ov;
    int           lat, bc;
    op(a, b, r, res, ov, lat, bc);
    chk({nm, "_result"}, 32'(res), 32'(eres));
    chk({nm, "_ovf"}, 32'(ov), 32'(eovf));
    chk({nm, "_latency"}, 32'(lat), 32'd9);
    chk({nm, "_busy_cycles"}, 32'(bc), 32'd8);
  endtask

  initial begin
    int d0, d1, nd;
    rst = 1; start = 0; m = '0; q = '0; rnd = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_result", 32'(o_result), 32'd0);
    chk("rst_ovf", 32'(o_ovf), 32'd0);
    rst = 0;

    dir("two_x_three",   16'h0100, 16'h0180, 1, 16'h0300, 0);
    dir("neg_one_x_2p5", 16'hFF80, 16'h0140, 1, 16'hFEC0, 0);
    dir("tiny_round",    16'h0001, 16'h0040, 1, 16'h0001, 0);
    dir("tiny_trunc",    16'h0001, 16'h0040, 0, 16'h0000, 0);
`ifdef MULT_BOOTH_SAT_EN
    dir("max_x_max",     16'h7FFF, 16'h7FFF, 0, 16'h7FFF, 1);
    dir("min_x_min",     16'h8000, 16'h8000, 0, 16'h7FFF, 1);
`else
    dir("max_x_max",     16'h7FFF, 16'h7FFF, 0, 16'hFE00, 1);
    dir("min_x_min",     16'h8000, 16'h8000, 0, 16'h0000, 1);
`endif

    // start held high: ops retire back-to-back every 9 cycles
    @(negedge clk);
    start = 1; m = 16'h0100; q = 16'h0180; rnd = 1;
    d0 = -1; d1 = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (o_done) begin
        if (d0 < 0) d0 = i;
        else if (d1 < 0) d1 = i;
      end
    end
    chk("b2b_first_done", 32'(d0), 32'd9);
    chk("b2b_period", 32'(d1 - d0), 32'd9);
    start = 0;
    repeat (12) @(negedge clk);

    // reset in the middle of an operation
    start = 1; m = 16'h7FFF; q = 16'h1234; rnd = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_done", 32'(o_done), 32'd0);
    chk("midrst_result", 32'(o_result), 32'd0);
    chk("midrst_ovf", 32'(o_ovf), 32'd0);
    @(negedge clk);
    rst = 0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_done) nd++;
    end
    chk("midrst_no_done", 32'(nd), 32'd0);

    // random traffic, start also pulsed while busy to confirm it is ignored
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0: m = 16'h8000;
        1: m = 16'h7FFF;
        2: m = 16'hFFFF;
        default: m = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: q = 16'h8000;
        1: q = 16'h7FFF;
        2: q = 16'h0001;
        default: q = W'($urandom);
      endcase
      rnd = 1'($urandom);
    end
    start = 0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
